// File: rtl/fact_cu.sv
// fact_cu: Moore control unit for the iterative factorial datapath.
// Sequences load / compare / multiply / decrement under a go/done/err handshake.
module fact_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       gt_in,
    input  logic       gt_fact,
    output logic       load_cnt,
    output logic       en,
    output logic       sel_1,
    output logic       load_reg,
    output logic       sel_2,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // Plain vector so codes 6/7 stay representable and recoverable.
    logic [2:0] state_q;
    logic [2:0] state_d;

    // State register, asynchronously cleared to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal codes fall back to IDLE.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (go && gt_in) begin
                    state_d = ERR;
                end else if (go) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:  state_d = CHECK;
            CHECK: state_d = gt_fact ? MULT : DONE;
            MULT:  state_d = CHECK;
            DONE:  state_d = go ? DONE : IDLE;
            ERR:   state_d = go ? ERR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state register only; illegal codes look like IDLE.
    always_comb begin
        load_cnt = 1'b0;
        en       = 1'b0;
        sel_1    = 1'b0;
        load_reg = 1'b0;
        sel_2    = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            LOAD: begin
                load_cnt = 1'b1;
                sel_1    = 1'b1;
                load_reg = 1'b1;
                busy     = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            MULT: begin
                load_reg = 1'b1;
                en       = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done  = 1'b1;
                sel_2 = 1'b0;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                sel_2 = 1'b1;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_fact_cu.sv
// tb_fact_cu: directed tests for fact_cu with a behavioural factorial datapath.
// Each scenario task drives stimulus and checks its own results inline.
module tb_fact_cu;

    logic       clk;
    logic       rst;
    logic       go;
    logic       gt_in;
    logic       gt_fact;
    logic       load_cnt;
    logic       en;
    logic       sel_1;
    logic       load_reg;
    logic       sel_2;
    logic       done;
    logic       err;
    logic       busy;
    logic [2:0] state;

    logic [4:0]  n;
    logic [4:0]  cnt;
    logic [31:0] prod;
    logic [31:0] nf;

    int errors;
    int checks;

    fact_cu dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .gt_in    (gt_in),
        .gt_fact  (gt_fact),
        .load_cnt (load_cnt),
        .en       (en),
        .sel_1    (sel_1),
        .load_reg (load_reg),
        .sel_2    (sel_2),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: down-counter and product register.
    always @(posedge clk) begin
        if (load_cnt) begin
            cnt <= n;
        end else if (en) begin
            cnt <= cnt - 5'd1;
        end
        if (load_reg) begin
            prod <= sel_1 ? 32'd1 : prod * {27'd0, cnt};
        end
    end

    assign gt_in   = (n > 5'd12);
    assign gt_fact = (cnt > 5'd1);
    assign nf      = sel_2 ? 32'd0 : prod;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until done rises (or budget expires), counting edges and strobes.
    task automatic run(input int max, output int edges, output int n_en,
                       output int n_ld, output int n_lr, output int n_s1,
                       output logic [63:0] hist);
        edges = -1;
        n_en  = 0;
        n_ld  = 0;
        n_lr  = 0;
        n_s1  = 0;
        hist  = '0;
        for (int i = 1; i <= max; i++) begin
            tick();
            hist = {hist[60:0], state};
            if (en) n_en++;
            if (load_cnt) n_ld++;
            if (load_reg) n_lr++;
            if (sel_1) n_s1++;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int e, a, b, c, d;
        logic [63:0] h;
        logic [10:0] o;
        rst = 1'b1;
        go  = 1'b0;
        n   = 5'd0;
        #12;
        o = {load_cnt, en, sel_1, load_reg, sel_2, done, err, busy, state};
        checks++;
        if (o !== 11'b00001000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", o, 11'b00001000000);
        end
        @(negedge clk);
        rst = 1'b0;
        n   = 5'd5;
        go  = 1'b1;
        run(3, e, a, b, c, d, h);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL reset_reach_mult got=%0d want=3", state);
        end
        #2;
        rst = 1'b1;
        #1;
        o = {load_cnt, en, sel_1, load_reg, sel_2, done, err, busy, state};
        checks++;
        if (o !== 11'b00001000000) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", o, 11'b00001000000);
        end
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd0 || sel_2 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release state=%0d sel_2=%b busy=%b want 0/1/0",
                     state, sel_2, busy);
        end
    endtask

    task automatic test_n5();
        int e, a, b, c, d;
        logic [63:0] h;
        logic ok;
        n  = 5'd5;
        go = 1'b1;
        run(40, e, a, b, c, d, h);
        checks++;
        if (e != 11) begin
            errors++;
            $display("FAIL n5_latency got=%0d want=11", e);
        end
        checks++;
        if (a != 4 || b != 1) begin
            errors++;
            $display("FAIL n5_pulses en=%0d load_cnt=%0d want 4/1", a, b);
        end
        checks++;
        if (nf !== 32'd120) begin
            errors++;
            $display("FAIL n5_result got=%0d want=120", nf);
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 1'b1 || sel_2 !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL n5_hold done=%b sel_2=%b want 1/0", done, sel_2);
        end
        go = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL n5_release done=%b state=%0d want 0/0", done, state);
        end
    endtask

    task automatic test_small();
        int e, a, b, c, d;
        logic [63:0] h;
        for (int k = 0; k < 2; k++) begin
            n  = (k == 0) ? 5'd0 : 5'd1;
            go = 1'b1;
            run(20, e, a, b, c, d, h);
            checks++;
            if (e != 3 || h[8:0] !== 9'b001_010_100) begin
                errors++;
                $display("FAIL small_seq n=%0d edges=%0d seq=%b want 3/001010100",
                         n, e, h[8:0]);
            end
            checks++;
            if (c != 1 || a != 0 || d != 1) begin
                errors++;
                $display("FAIL small_strobes n=%0d load_reg=%0d en=%0d sel_1=%0d want 1/0/1",
                         n, c, a, d);
            end
            checks++;
            if (nf !== 32'd1) begin
                errors++;
                $display("FAIL small_result n=%0d got=%0d want=1", n, nf);
            end
            go = 1'b0;
            tick();
        end
    endtask

    task automatic test_err();
        int strobes;
        n  = 5'd13;
        go = 1'b1;
        tick();
        checks++;
        if (err !== 1'b1 || sel_2 !== 1'b1 || state !== 3'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_entry err=%b sel_2=%b state=%0d busy=%b want 1/1/5/0",
                     err, sel_2, state, busy);
        end
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load_cnt || en || load_reg || err !== 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL err_hold bad_cycles=%0d want=0", strobes);
        end
        go = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_release state=%0d err=%b want 0/0", state, err);
        end
    endtask

    task automatic test_back_to_back();
        int e, a, b, c, d, bad;
        logic [63:0] h;
        n  = 5'd3;
        go = 1'b1;
        run(30, e, a, b, c, d, h);
        checks++;
        if (e != 7 || nf !== 32'd6) begin
            errors++;
            $display("FAIL b2b_first edges=%0d nf=%0d want 7/6", e, nf);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== 3'd4) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_no_retrigger bad_cycles=%0d want=0", bad);
        end
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || load_cnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart state=%0d load_cnt=%b want 1/1", state, load_cnt);
        end
        run(30, e, a, b, c, d, h);
        checks++;
        if (e != 6 || nf !== 32'd6) begin
            errors++;
            $display("FAIL b2b_second edges=%0d nf=%0d want 6/6", e, nf);
        end
        go = 1'b0;
        tick();
    endtask

    task automatic test_drop_mid();
        int e, a, b, c, d;
        logic [63:0] h;
        n  = 5'd4;
        go = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL drop_in_mult state=%0d want=3", state);
        end
        go = 1'b0;
        run(30, e, a, b, c, d, h);
        checks++;
        if (e != 6 || nf !== 32'd24) begin
            errors++;
            $display("FAIL drop_complete edges=%0d nf=%0d want 6/24", e, nf);
        end
        tick();
        checks++;
        if (done !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL drop_one_cycle done=%b state=%0d want 0/0", done, state);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] o;
        go = 1'b0;
        @(negedge clk);
        force dut.state_q = 3'd7;
        #1;
        o = {load_cnt, en, sel_1, load_reg, sel_2, done, err, busy, state};
        checks++;
        if (o !== 11'b00001000111) begin
            errors++;
            $display("FAIL illegal_outputs got=%b want=%b", o, 11'b00001000111);
        end
        release dut.state_q;
        tick();
        o = {load_cnt, en, sel_1, load_reg, sel_2, done, err, busy, state};
        checks++;
        if (o !== 11'b00001000000) begin
            errors++;
            $display("FAIL illegal_recover got=%b want=%b", o, 11'b00001000000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        go     = 1'b0;
        n      = 5'd0;
        rst    = 1'b1;
        test_reset();
        test_n5();
        test_small();
        test_err();
        test_back_to_back();
        test_drop_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
